// File: rtl/vga_scan_engine.sv
// vga_scan_engine: programmable VGA timing generator and scaled frame-buffer scan-out.
//
// Counts pixel clocks (h_count) and lines (v_count), issues a source-pixel read address for
// positions inside the centred image window, and carries per-position flags down a
// FETCH_LATENCY-deep pipeline so that video, sync and status leave the output register
// aligned with the returning pixel data.
//
// Ports:
//   vga_clk         pixel clock, all state on its rising edge
//   reset_n         asynchronous active-low reset
//   read_pixel_num  source pixel address y_src*SRC_W + x_src (0 outside the window)
//   read_en         read_pixel_num addresses an in-window pixel
//   read_pixel_rgb  {r,g,b} returned FETCH_LATENCY clocks after its address
//   vga_r/g/b       registered video
//   vga_hs/vga_vs   registered sync, asserted level set by HS_POL / VS_POL
//   frame_start     one-clock pulse at position (0,0), output-aligned
//   vblank          high on lines outside vertical active, output-aligned
module vga_scan_engine #(
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int unsigned SRC_W         = 256,
  parameter int unsigned SRC_H         = 240,
  parameter int unsigned SCALE         = 2,
  parameter int unsigned FETCH_LATENCY = 2,
  parameter logic [11:0] BORDER_RGB    = 12'h000,
  parameter int unsigned ADDR_W        = $clog2(SRC_W * SRC_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] read_pixel_num,
  output logic              read_en,
  input  logic [11:0]       read_pixel_rgb,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start,
  output logic              vblank
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

  localparam int unsigned HOFF        = (H_ACTIVE - SRC_W * SCALE) / 2;
  localparam int unsigned VOFF        = (V_ACTIVE - SRC_H * SCALE) / 2;
  localparam int unsigned H_WIN_START = H_ACT_START + HOFF;
  localparam int unsigned H_WIN_END   = H_WIN_START + SRC_W * SCALE;
  localparam int unsigned V_WIN_START = V_ACT_START + VOFF;
  localparam int unsigned V_WIN_END   = V_WIN_START + SRC_H * SCALE;

  localparam int unsigned SHIFT = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);

  // Elaboration-time parameter checks
  if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_bad_scale
    $fatal(1, "vga_scan_engine: SCALE must be 1, 2 or 4");
  end
  if (SRC_W * SCALE > H_ACTIVE) begin : g_bad_width
    $fatal(1, "vga_scan_engine: SRC_W*SCALE exceeds H_ACTIVE");
  end
  if (SRC_H * SCALE > V_ACTIVE) begin : g_bad_height
    $fatal(1, "vga_scan_engine: SRC_H*SCALE exceeds V_ACTIVE");
  end
  if (FETCH_LATENCY < 1) begin : g_bad_latency
    $fatal(1, "vga_scan_engine: FETCH_LATENCY must be at least 1");
  end

  typedef struct packed {
    logic win;
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic vb;
  } flags_t;

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_count_q;
  logic [VW-1:0] v_count_q;
  logic [31:0]   h_ext;
  logic [31:0]   v_ext;
  logic          h_last;
  logic          v_last;

  assign h_ext  = 32'(h_count_q);
  assign v_ext  = 32'(v_count_q);
  assign h_last = (h_ext == H_TOTAL - 1);
  assign v_last = (v_ext == V_TOTAL - 1);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else if (h_last) begin
      h_count_q <= '0;
      v_count_q <= v_last ? '0 : v_count_q + 1'b1;
    end else begin
      h_count_q <= h_count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: classification and address generation
  // ---------------------------------------------------------------------------
  logic              h_act;
  logic              v_act;
  logic              h_win;
  logic              v_win;
  logic              in_win;
  logic [ADDR_W-1:0] x_src;
  logic [ADDR_W-1:0] y_src;
  flags_t            raw;

  assign h_act  = (h_ext >= H_ACT_START) && (h_ext < H_ACT_END);
  assign v_act  = (v_ext >= V_ACT_START) && (v_ext < V_ACT_END);
  assign h_win  = (h_ext >= H_WIN_START) && (h_ext < H_WIN_END);
  assign v_win  = (v_ext >= V_WIN_START) && (v_ext < V_WIN_END);
  assign in_win = h_win && v_win;

  // Offsets are only meaningful inside the window; outside, the address is forced to 0.
  assign x_src = ADDR_W'((h_ext - H_WIN_START) >> SHIFT);
  assign y_src = ADDR_W'((v_ext - V_WIN_START) >> SHIFT);

  assign read_pixel_num = in_win ? ADDR_W'(y_src * SRC_W) + x_src : '0;
  assign read_en        = in_win && reset_n;

  always_comb begin
    raw     = '0;
    raw.win = in_win;
    raw.act = h_act && v_act;
    raw.hs  = (h_ext < H_SYNC);
    raw.vs  = (v_ext < V_SYNC);
    raw.fs  = (h_count_q == '0) && (v_count_q == '0);
    raw.vb  = !v_act;
  end

  // ---------------------------------------------------------------------------
  // Flag pipeline, matched to the frame-buffer read latency
  // ---------------------------------------------------------------------------
  flags_t pipe_q [FETCH_LATENCY];
  flags_t last;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FETCH_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i < FETCH_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign last = pipe_q[FETCH_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_d, rgb_q;
  logic        hs_d, hs_q;
  logic        vs_d, vs_q;
  logic        fs_q;
  logic        vb_q;

  always_comb begin
    rgb_d = 12'h000;
    if (last.win) begin
      rgb_d = read_pixel_rgb;
    end else if (last.act) begin
      rgb_d = BORDER_RGB;
    end
    hs_d = last.hs ? HS_POL : ~HS_POL;
    vs_d = last.vs ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= 12'h000;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      fs_q  <= 1'b0;
      vb_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= last.fs;
      vb_q  <= last.vb;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;
  assign vblank      = vb_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine.
//   u_a: default timing, BORDER_RGB=00F, 2-clock memory model.
//   u_b: SCALE=1, FETCH_LATENCY=3, HS_POL=1; V_ACTIVE=240 so the window starts on line 35
//        and can be reached in a short run (HOFF=192, VOFF=0).
//   u_c: tiny raster (24 x 12) so whole frames and the frame wrap fit in the run.
// Memory models return ABC for in-window reads and 5A5 otherwise.
module tb_vga_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1;

  int vectors = 0;
  int errors  = 0;
  int n       = 0;

  // ---------------- instance A ----------------
  logic [15:0] a_addr;
  logic        a_en;
  logic [11:0] a_rgb_in, a_m1, a_m2;
  logic [3:0]  a_r, a_g, a_b;
  logic        a_hs, a_vs, a_fs, a_vb;

  always @(posedge clk) begin
    a_m1 <= a_en ? 12'hABC : 12'h5A5;
    a_m2 <= a_m1;
  end
  assign a_rgb_in = a_m2;

  vga_scan_engine #(
    .BORDER_RGB(12'h00F)
  ) u_a (
    .vga_clk(clk), .reset_n(reset_n), .read_pixel_num(a_addr), .read_en(a_en),
    .read_pixel_rgb(a_rgb_in), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hs(a_hs), .vga_vs(a_vs), .frame_start(a_fs), .vblank(a_vb)
  );

  // ---------------- instance B ----------------
  logic [15:0] b_addr;
  logic        b_en;
  logic [11:0] b_rgb_in, b_m1, b_m2, b_m3;
  logic [3:0]  b_r, b_g, b_b;
  logic        b_hs, b_vs, b_fs, b_vb;

  always @(posedge clk) begin
    b_m1 <= b_en ? 12'hABC : 12'h5A5;
    b_m2 <= b_m1;
    b_m3 <= b_m2;
  end
  assign b_rgb_in = b_m3;

  vga_scan_engine #(
    .V_ACTIVE(240), .HS_POL(1'b1), .SCALE(1), .FETCH_LATENCY(3), .BORDER_RGB(12'h00F)
  ) u_b (
    .vga_clk(clk), .reset_n(reset_n), .read_pixel_num(b_addr), .read_en(b_en),
    .read_pixel_rgb(b_rgb_in), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hs(b_hs), .vga_vs(b_vs), .frame_start(b_fs), .vblank(b_vb)
  );

  // ---------------- instance C ----------------
  logic [4:0]  c_addr;
  logic        c_en;
  logic [11:0] c_rgb_in, c_m1;
  logic [3:0]  c_r, c_g, c_b;
  logic        c_hs, c_vs, c_fs, c_vb;

  always @(posedge clk) c_m1 <= c_en ? 12'hABC : 12'h5A5;
  assign c_rgb_in = c_m1;

  vga_scan_engine #(
    .H_SYNC(4), .H_BACK(2), .H_ACTIVE(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(8), .V_FRONT(1),
    .SRC_W(8), .SRC_H(4), .SCALE(2), .FETCH_LATENCY(1), .BORDER_RGB(12'h00F)
  ) u_c (
    .vga_clk(clk), .reset_n(reset_n), .read_pixel_num(c_addr), .read_en(c_en),
    .read_pixel_rgb(c_rgb_in), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
    .vga_hs(c_hs), .vga_vs(c_vs), .frame_start(c_fs), .vblank(c_vb)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic go_to(input int target);
    while (n < target) step();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_rgb"}, {a_r, a_g, a_b}, 12'h000);
    check({tag, "_hs"}, a_hs, 1'b1);
    check({tag, "_vs"}, a_vs, 1'b1);
    check({tag, "_fs"}, a_fs, 1'b0);
    check({tag, "_vb"}, a_vb, 1'b0);
    check({tag, "_en"}, a_en, 1'b0);
    check({tag, "_b_hs"}, b_hs, 1'b0);
  endtask

  int a_hs_lo = 0, b_hs_hi = 0, c_hs_lo = 0, c_vs_lo = 0;
  int c_fs_cnt = 0, c_fs1 = 0, c_fs2 = 0;
  int a_abc = 0, a_bdr = 0, a_blk = 0, b_abc = 0, b_bdr = 0, b_blk = 0;

  initial begin
    // Power-on reset
    #2 reset_n = 1'b0;
    #1 check_reset_a("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;

    // Mid-line reset: outputs return to reset values without a clock edge
    go_to(50);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_reset_a("mid");
    repeat (5) @(posedge clk);
    #1 check_reset_a("held");
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;

    // frame_start latency after release: A at 3, B at 4, C at 2
    step(); step();
    check("a_fs_n2", a_fs, 1'b0);
    check("c_fs_n2", c_fs, 1'b1);
    step();
    check("a_fs_n3", a_fs, 1'b1);
    check("a_hs_n3", a_hs, 1'b0);
    check("a_vs_n3", a_vs, 1'b0);
    check("a_vb_n3", a_vb, 1'b1);
    check("b_fs_n3", b_fs, 1'b0);
    step();
    check("a_fs_n4", a_fs, 1'b0);
    check("b_fs_n4", b_fs, 1'b1);
    check("b_hs_n4", b_hs, 1'b1);

    // One line of sync widths, plus whole frames of the small raster
    while (n < 804) begin
      step();
      if (a_hs == 1'b0) a_hs_lo++;
      if (b_hs == 1'b1) b_hs_hi++;
      if (c_hs == 1'b0) c_hs_lo++;
      if (c_vs == 1'b0) c_vs_lo++;
      if (c_fs) begin
        c_fs_cnt++;
        if (c_fs_cnt == 1) c_fs1 = n;
        else if (c_fs_cnt == 2) c_fs2 = n;
      end
    end
    check("a_hs_low_per_line", a_hs_lo, 96);
    check("b_hs_high_per_line", b_hs_hi, 96);
    check("c_hs_low", c_hs_lo, 133);
    check("c_vs_low", c_vs_lo, 141);
    check("c_fs_count", c_fs_cnt, 2);
    check("c_fs_first", c_fs1, 290);
    check("c_fs_second", c_fs2, 578);

    // Vertical sync edge: line 1 -> line 2
    go_to(1602);
    check("a_vs_line1", a_vs, 1'b0);
    step();
    check("a_vs_line2", a_vs, 1'b1);

    // vblank falls at the first active line (output position v=35, h=0 -> n=28003)
    go_to(28002);
    check("a_vb_line34", a_vb, 1'b1);

    // Line 35: addresses and colour path
    while (n < 28803) begin
      step();
      if (n <= 28802) begin
        case ({a_r, a_g, a_b})
          12'hABC: a_abc++;
          12'h00F: a_bdr++;
          12'h000: a_blk++;
          default: ;
        endcase
      end
      if (n >= 28004) begin
        case ({b_r, b_g, b_b})
          12'hABC: b_abc++;
          12'h00F: b_bdr++;
          12'h000: b_blk++;
          default: ;
        endcase
      end
      case (n)
        28003: check("a_vb_line35", a_vb, 1'b0);
        28146: check("a_rgb_h143", {a_r, a_g, a_b}, 12'h000);
        28147: check("a_rgb_h144", {a_r, a_g, a_b}, 12'h00F);
        28207: check("a_en_h207", a_en, 1'b0);
        28208: begin
          check("a_en_h208", a_en, 1'b1);
          check("a_addr_h208", a_addr, 16'd0);
        end
        28209: check("a_addr_h209", a_addr, 16'd0);
        28210: begin
          check("a_addr_h210", a_addr, 16'd1);
          check("a_rgb_h207", {a_r, a_g, a_b}, 12'h00F);
        end
        28211: check("a_rgb_h208", {a_r, a_g, a_b}, 12'hABC);
        28335: check("b_en_h335", b_en, 1'b0);
        28336: begin
          check("b_en_h336", b_en, 1'b1);
          check("b_addr_h336", b_addr, 16'd0);
        end
        28337: check("b_addr_h337", b_addr, 16'd1);
        28339: check("b_rgb_h335", {b_r, b_g, b_b}, 12'h00F);
        28340: check("b_rgb_h336", {b_r, b_g, b_b}, 12'hABC);
        28591: check("b_addr_h591", b_addr, 16'd255);
        28592: check("b_en_h592", b_en, 1'b0);
        28719: begin
          check("a_en_h719", a_en, 1'b1);
          check("a_addr_h719", a_addr, 16'd255);
        end
        28720: begin
          check("a_en_h720", a_en, 1'b0);
          check("a_addr_h720", a_addr, 16'd0);
        end
        28722: check("a_rgb_h719", {a_r, a_g, a_b}, 12'hABC);
        28723: check("a_rgb_h720", {a_r, a_g, a_b}, 12'h00F);
        default: ;
      endcase
    end
    check("a_window_count", a_abc, 512);
    check("a_border_count", a_bdr, 128);
    check("a_blank_count", a_blk, 160);
    check("b_window_count", b_abc, 256);
    check("b_border_count", b_bdr, 384);
    check("b_blank_count", b_blk, 160);

    // Scaled rows: line 36 repeats source row 0, line 37 is source row 1
    go_to(29008);
    check("a_en_v36", a_en, 1'b1);
    check("a_addr_v36", a_addr, 16'd0);
    go_to(29136);
    check("b_addr_v36", b_addr, 16'd256);
    go_to(29808);
    check("a_addr_v37", a_addr, 16'd256);

    // read_en drops as soon as reset is asserted
    reset_n = 1'b0;
    #1 check("a_en_in_reset", a_en, 1'b0);
    check("a_rgb_in_reset", {a_r, a_g, a_b}, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
